// File: rtl/seg_scan_display_pkg.sv
// Shared constants for the 8-digit multiplexed 7-segment display:
// glyph codes, raw segment patterns (bit order g..a) and scan FSM states.
package seg_scan_display_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [4:0] CODE_BLANK = 5'd16;
  localparam logic [4:0] CODE_MINUS = 5'd17;
  localparam logic [4:0] CODE_R     = 5'd18;
  localparam logic [4:0] CODE_O     = 5'd19;
  localparam logic [4:0] CODE_N     = 5'd20;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_R     = 7'h50;
  localparam logic [6:0] SEG_O     = 7'h5C;
  localparam logic [6:0] SEG_N     = 7'h54;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [0:0] {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg_scan_display_seg7_decode.sv
// Combinational glyph decoder: 5-bit display code to active-high g..a segments.
// Codes outside the defined glyph set render as blank.
module seg7_decode
  import seg_scan_display_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] seg
);

  // glyph lookup
  always_comb begin
    seg = SEG_BLANK;
    case (code)
      5'd0:       seg = SEG_0;
      5'd1:       seg = SEG_1;
      5'd2:       seg = SEG_2;
      5'd3:       seg = SEG_3;
      5'd4:       seg = SEG_4;
      5'd5:       seg = SEG_5;
      5'd6:       seg = SEG_6;
      5'd7:       seg = SEG_7;
      5'd8:       seg = SEG_8;
      5'd9:       seg = SEG_9;
      5'd10:      seg = SEG_A;
      5'd11:      seg = SEG_B;
      5'd12:      seg = SEG_C;
      5'd13:      seg = SEG_D;
      5'd14:      seg = SEG_E;
      5'd15:      seg = SEG_F;
      CODE_MINUS: seg = SEG_MINUS;
      CODE_R:     seg = SEG_R;
      CODE_O:     seg = SEG_O;
      CODE_N:     seg = SEG_N;
      default:    seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed 8-digit 7-segment driver with pending/active double buffering
// so a producer update is only ever applied at a frame boundary.
module seg_scan_display
  import seg_scan_display_pkg::*;
#(
  parameter int DIGIT_CYC  = 1500,
  parameter int BLANK_CYC  = 64,
  parameter bit SEG_ACT_LO = 1'b1,
  parameter bit SEL_ACT_LO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [39:0] seg_data,
  input  logic [7:0]  seg_data_en,
  input  logic [7:0]  seg_dot_en,
  input  logic        load,
  output logic [7:0]  seg_led,
  output logic [7:0]  seg_sel,
  output logic        frame_done
);

  localparam int CNT_W = $clog2(DIGIT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYC - 1);
  localparam logic [CNT_W-1:0] SHOW_END = CNT_W'(DIGIT_CYC - BLANK_CYC);
  localparam logic [2:0]       IDX_LAST = 3'(NUM_DIGITS - 1);
  localparam logic [7:0]       LED_OFF  = SEG_ACT_LO ? 8'hFF : 8'h00;
  localparam logic [7:0]       SEL_OFF  = SEL_ACT_LO ? 8'hFF : 8'h00;

  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [2:0]       idx_r, idx_nxt_s;
  scan_state_e      state_r, state_nxt_s;
  logic             boundary_s;

  logic [39:0] pend_data_r, act_data_r;
  logic [7:0]  pend_en_r, pend_dot_r, act_en_r, act_dot_r;
  logic        dirty_r;

  logic [5:0]  bit_base_s;
  logic [4:0]  cur_code_s;
  logic [6:0]  glyph_s;
  logic [7:0]  led_raw_s, sel_raw_s;
  logic [7:0]  seg_led_r, seg_sel_r;
  logic        frame_done_r;

  // slot counter and digit index sequencing
  always_comb begin
    cnt_nxt_s = cnt_r;
    idx_nxt_s = idx_r;
    if (cnt_r == CNT_LAST) begin
      cnt_nxt_s = '0;
      idx_nxt_s = idx_r + 3'd1;
    end else begin
      cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      idx_nxt_s = idx_r;
    end
    boundary_s = (cnt_r == CNT_LAST) && (idx_r == IDX_LAST);
  end

  // state register: counter, index and scan FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r   <= '0;
      idx_r   <= 3'd0;
      state_r <= ST_SHOW;
    end else begin
      cnt_r   <= cnt_nxt_s;
      idx_r   <= idx_nxt_s;
      state_r <= state_nxt_s;
    end
  end

  // next-state: blank the tail of every slot, show again at the next slot start
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_SHOW: begin
        if (cnt_nxt_s == SHOW_END) state_nxt_s = ST_BLANK;
        else                       state_nxt_s = ST_SHOW;
      end
      ST_BLANK: begin
        if (cnt_nxt_s == '0) state_nxt_s = ST_SHOW;
        else                 state_nxt_s = ST_BLANK;
      end
      default: state_nxt_s = ST_SHOW;
    endcase
  end

  // pending capture on load; active swap only at the frame boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_data_r <= {NUM_DIGITS{CODE_BLANK}};
      pend_en_r   <= 8'h00;
      pend_dot_r  <= 8'h00;
      act_data_r  <= {NUM_DIGITS{CODE_BLANK}};
      act_en_r    <= 8'h00;
      act_dot_r   <= 8'h00;
      dirty_r     <= 1'b0;
    end else begin
      if (load) begin
        pend_data_r <= seg_data;
        pend_en_r   <= seg_data_en;
        pend_dot_r  <= seg_dot_en;
      end
      if (boundary_s) begin
        dirty_r <= 1'b0;
        if (load) begin
          act_data_r <= seg_data;
          act_en_r   <= seg_data_en;
          act_dot_r  <= seg_dot_en;
        end else if (dirty_r) begin
          act_data_r <= pend_data_r;
          act_en_r   <= pend_en_r;
          act_dot_r  <= pend_dot_r;
        end
      end else if (load) begin
        dirty_r <= 1'b1;
      end
    end
  end

  assign bit_base_s = {3'b000, idx_r} * 6'd5;
  assign cur_code_s = act_data_r[bit_base_s +: 5];

  seg7_decode u_decode (
    .code (cur_code_s),
    .seg  (glyph_s)
  );

  // output decode: select and segments for the current slot, all off while blanking
  always_comb begin
    sel_raw_s = 8'h00;
    led_raw_s = 8'h00;
    case (state_r)
      ST_SHOW: begin
        sel_raw_s = 8'h01 << idx_r;
        if (act_en_r[idx_r]) led_raw_s = {act_dot_r[idx_r], glyph_s};
        else                 led_raw_s = 8'h00;
      end
      ST_BLANK: begin
        sel_raw_s = 8'h00;
        led_raw_s = 8'h00;
      end
      default: begin
        sel_raw_s = 8'h00;
        led_raw_s = 8'h00;
      end
    endcase
  end

  // registered pin drivers; frame_done is high during the boundary cycle itself
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_led_r    <= LED_OFF;
      seg_sel_r    <= SEL_OFF;
      frame_done_r <= 1'b0;
    end else begin
      seg_led_r    <= SEG_ACT_LO ? ~led_raw_s : led_raw_s;
      seg_sel_r    <= SEL_ACT_LO ? ~sel_raw_s : sel_raw_s;
      frame_done_r <= (cnt_nxt_s == CNT_LAST) && (idx_nxt_s == IDX_LAST);
    end
  end

  assign seg_led    = seg_led_r;
  assign seg_sel    = seg_sel_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: directed scenarios plus random loads, every cycle
// compared against a frame-position model of the display.
module tb_seg_scan_display;

  localparam int DC    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 8 * DC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [39:0] seg_data;
  logic [7:0]  seg_data_en = 8'h00;
  logic [7:0]  seg_dot_en  = 8'h00;
  logic        load = 1'b0;
  logic [7:0]  seg_led, seg_sel;
  logic        frame_done;

  logic [4:0]  in_code [8];
  logic [6:0]  glyph [32];

  int          m_pos, m_dirty;
  int          m_pcode [8];
  int          m_acode [8];
  logic [7:0]  m_pen, m_pdot, m_aen, m_adot;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  seg_scan_display #(
    .DIGIT_CYC  (DC),
    .BLANK_CYC  (BC),
    .SEG_ACT_LO (1'b1),
    .SEL_ACT_LO (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_data    (seg_data),
    .seg_data_en (seg_data_en),
    .seg_dot_en  (seg_dot_en),
    .load        (load),
    .seg_led     (seg_led),
    .seg_sel     (seg_sel),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  always_comb begin
    seg_data = '0;
    for (int i = 0; i < 8; i++) seg_data[i*5 +: 5] = in_code[i];
  end

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s at pos %0d: observed %h expected %h", tag, m_pos, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0;
    m_dirty = 0;
    m_pen = 8'h00; m_pdot = 8'h00; m_aen = 8'h00; m_adot = 8'h00;
    for (int i = 0; i < 8; i++) begin
      m_pcode[i] = 16;
      m_acode[i] = 16;
    end
  endtask

  // one clock: advance the model with the inputs seen at the edge, compare on the falling edge
  task automatic tick();
    int idx, cnt;
    logic [7:0] e_led, e_sel, e_fd;
    @(posedge clk);
    e_led = 8'hFF;
    e_sel = 8'hFF;
    e_fd  = 8'h00;
    if (rst) begin
      model_reset();
    end else begin
      idx = m_pos / DC;
      cnt = m_pos % DC;
      if (cnt < DC - BC) begin
        e_sel = ~(8'h01 << idx);
        if (m_aen[idx]) e_led = ~{m_adot[idx], glyph[m_acode[idx]]};
      end
      if (m_pos == FRAME - 1) begin
        if (load) begin
          for (int i = 0; i < 8; i++) m_acode[i] = int'(in_code[i]);
          m_aen = seg_data_en; m_adot = seg_dot_en;
        end else if (m_dirty != 0) begin
          for (int i = 0; i < 8; i++) m_acode[i] = m_pcode[i];
          m_aen = m_pen; m_adot = m_pdot;
        end
        m_dirty = 0;
      end else if (load) begin
        m_dirty = 1;
      end
      if (load) begin
        for (int i = 0; i < 8; i++) m_pcode[i] = int'(in_code[i]);
        m_pen = seg_data_en; m_pdot = seg_dot_en;
      end
      m_pos = (m_pos + 1) % FRAME;
      e_fd = (m_pos == FRAME - 1) ? 8'h01 : 8'h00;
    end
    @(negedge clk);
    check8("seg_led", seg_led, e_led);
    check8("seg_sel", seg_sel, e_sel);
    check8("frame_done", {7'd0, frame_done}, e_fd);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_to(input int pos);
    for (int i = 0; i < FRAME && m_pos != pos; i++) tick();
  endtask

  task automatic do_load(input logic [7:0] en, input logic [7:0] dot);
    seg_data_en = en;
    seg_dot_en  = dot;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic rand_codes(input int lo, input int hi);
    for (int i = 0; i < 8; i++) in_code[i] = 5'($urandom_range(hi, lo));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) glyph[i] = 7'h00;
    glyph[0] = 7'h3F; glyph[1] = 7'h06; glyph[2] = 7'h5B; glyph[3] = 7'h4F;
    glyph[4] = 7'h66; glyph[5] = 7'h6D; glyph[6] = 7'h7D; glyph[7] = 7'h07;
    glyph[8] = 7'h7F; glyph[9] = 7'h6F; glyph[10] = 7'h77; glyph[11] = 7'h7C;
    glyph[12] = 7'h39; glyph[13] = 7'h5E; glyph[14] = 7'h79; glyph[15] = 7'h71;
    glyph[17] = 7'h40; glyph[18] = 7'h50; glyph[19] = 7'h5C; glyph[20] = 7'h54;
    for (int i = 0; i < 8; i++) in_code[i] = 5'd0;
    model_reset();

    // reset held for three cycles
    rst = 1'b1;
    run(3);
    rst = 1'b0;

    // digits 1..8, all enabled, no dots
    for (int i = 0; i < 8; i++) in_code[i] = 5'(i + 1);
    do_load(8'hFF, 8'h00);
    run(2 * FRAME);

    // minus with dot on digit1 only; digit2 dot suppressed by its enable
    rand_codes(0, 20);
    in_code[0] = 5'd17;
    do_load(8'h01, 8'h03);
    run(2 * FRAME);

    // two loads inside one frame: only the second may appear
    run_to(20);
    rand_codes(0, 20);
    do_load(8'hFF, 8'($urandom));
    run(4);
    rand_codes(0, 20);
    do_load(8'($urandom), 8'($urandom));
    run(FRAME + 10);

    // load coincident with the frame boundary
    run_to(FRAME - 1);
    rand_codes(0, 20);
    do_load(8'hFF, 8'($urandom));
    run(FRAME + 4);

    // random loads and unloaded data wiggles
    for (int c = 0; c < 12 * FRAME; c++) begin
      rand_codes(0, 31);
      seg_data_en = 8'($urandom);
      seg_dot_en  = 8'($urandom);
      load = ($urandom_range(15, 0) == 0);
      tick();
    end
    load = 1'b0;

    // async reset in the middle of the digit5 slot
    run_to(4 * DC + 2);
    rst = 1'b1;
    #1;
    check8("async_led", seg_led, 8'hFF);
    check8("async_sel", seg_sel, 8'hFF);
    check8("async_fd", {7'd0, frame_done}, 8'h00);
    run(2);
    rst = 1'b0;
    run(FRAME + 5);

    // codes 21..31 decode blank, only dots can light
    rand_codes(21, 31);
    do_load(8'hFF, 8'($urandom));
    run(2 * FRAME);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
